// File: rtl/score_keeper.sv
// Basketball scoreboard stage: conditions the point buttons, validates each
// add/subtract against the score range and keeps both teams' scores plus BCD digits.
//
// state  | meaning
// -------+-----------------------------------------------------------------
// IDLE   | waiting for a debounced press edge
// CHECK  | latched operation is tested against the selected team's score
// UPDATE | score written, point_event high for this cycle
// ALARM  | rejected operation, buzzer on for BUZZ_CYCLES cycles
module score_keeper #(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int BUZZ_CYCLES     = 25000000,
    parameter int MAX_SCORE       = 99        // must stay <= 127
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       btn_a,
    input  logic       btn_b,
    input  logic       btn_c,
    input  logic       sub_mode,
    input  logic       team_sel,
    output logic [6:0] score_t0,
    output logic [6:0] score_t1,
    output logic [3:0] tens_t0,
    output logic [3:0] units_t0,
    output logic [3:0] tens_t1,
    output logic [3:0] units_t1,
    output logic [1:0] point_value,
    output logic       point_event,
    output logic       buzzer,
    output logic       led
);

    localparam int DEB_W  = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int BUZZ_W = $clog2(BUZZ_CYCLES + 1);
    localparam logic [DEB_W-1:0]  DEB_LAST  = DEB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [BUZZ_W-1:0] BUZZ_LAST = BUZZ_W'(BUZZ_CYCLES - 1);
    localparam logic [7:0]        MAX_8     = 8'(MAX_SCORE);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        CHECK  = 2'd1,
        UPDATE = 2'd2,
        ALARM  = 2'd3
    } state_t;

    state_t state, state_nxt;

    logic [2:0]       btn_raw;
    logic [2:0]       btn_s1;
    logic [2:0]       btn_s2;
    logic [2:0]       level;
    logic [2:0]       level_q;
    logic [DEB_W-1:0] deb_cnt [3];
    logic [2:0]       press;
    logic             press_one;
    logic             press_multi;
    logic [1:0]       press_val;

    logic [1:0] sw_s1;
    logic [1:0] sw_s2;

    logic [1:0]        val_l;
    logic              team_l;
    logic              sub_l;
    logic [6:0]        score0;
    logic [6:0]        score1;
    logic [BUZZ_W-1:0] buzz_cnt;

    logic [6:0] s_sel;
    logic [7:0] sum8;
    logic       add_ok;
    logic       sub_ok;
    logic       legal;
    logic [6:0] new_score;
    logic       alarm_entry;

    assign btn_raw = {btn_c, btn_b, btn_a};

    // The counter only runs while the synchronised input disagrees with the
    // accepted level, so any return to the old value restarts the wait.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            btn_s1  <= '0;
            btn_s2  <= '0;
            level   <= '0;
            level_q <= '0;
            for (int i = 0; i < 3; i++) begin
                deb_cnt[i] <= '0;
            end
        end else begin
            btn_s1  <= btn_raw;
            btn_s2  <= btn_s1;
            level_q <= level;
            for (int i = 0; i < 3; i++) begin
                if (btn_s2[i] == level[i]) begin
                    deb_cnt[i] <= '0;
                end else if (deb_cnt[i] == DEB_LAST) begin
                    level[i]   <= btn_s2[i];
                    deb_cnt[i] <= '0;
                end else begin
                    deb_cnt[i] <= deb_cnt[i] + 1'b1;
                end
            end
        end
    end

    assign press       = level & ~level_q;
    assign press_one   = (press == 3'b001) || (press == 3'b010) || (press == 3'b100);
    assign press_multi = (press[0] & press[1]) | (press[0] & press[2]) | (press[1] & press[2]);

    always_comb begin
        press_val = 2'd0;
        case (press)
            3'b001:  press_val = 2'd1;
            3'b010:  press_val = 2'd2;
            3'b100:  press_val = 2'd3;
            default: press_val = 2'd0;
        endcase
    end

    // Switches are quasi-static: synchronised only, bit 1 = team, bit 0 = sub.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sw_s1 <= '0;
            sw_s2 <= '0;
        end else begin
            sw_s1 <= {team_sel, sub_mode};
            sw_s2 <= sw_s1;
        end
    end

    assign s_sel     = team_l ? score1 : score0;
    assign sum8      = {1'b0, s_sel} + {6'b0, val_l};
    assign add_ok    = (sum8 <= MAX_8);
    assign sub_ok    = ({5'b0, val_l} <= s_sel);
    assign legal     = sub_l ? sub_ok : add_ok;
    assign new_score = sub_l ? (s_sel - {5'b0, val_l}) : sum8[6:0];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (press_multi) begin
                    state_nxt = ALARM;
                end else if (press_one) begin
                    state_nxt = CHECK;
                end
            end
            CHECK:   state_nxt = legal ? UPDATE : ALARM;
            UPDATE:  state_nxt = IDLE;
            ALARM:   state_nxt = (buzz_cnt == '0) ? IDLE : ALARM;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        point_event = 1'b0;
        buzzer      = 1'b0;
        case (state)
            UPDATE:  point_event = 1'b1;
            ALARM:   buzzer      = 1'b1;
            default: ;
        endcase
    end

    assign alarm_entry = (state != ALARM) && (state_nxt == ALARM);

    // The score is written on the CHECK->UPDATE transition so the new value
    // is already visible in the cycle where point_event is high.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            val_l       <= '0;
            team_l      <= 1'b0;
            sub_l       <= 1'b0;
            score0      <= '0;
            score1      <= '0;
            point_value <= '0;
            led         <= 1'b0;
            buzz_cnt    <= '0;
        end else begin
            if (state == IDLE && press_one) begin
                val_l  <= press_val;
                team_l <= sw_s2[1];
                sub_l  <= sw_s2[0];
            end
            if (state == CHECK && legal) begin
                if (team_l) begin
                    score1 <= new_score;
                end else begin
                    score0 <= new_score;
                end
                point_value <= val_l;
                led         <= 1'b0;
            end
            if (alarm_entry) begin
                led      <= 1'b1;
                buzz_cnt <= BUZZ_LAST;
            end else if (state == ALARM && buzz_cnt != '0) begin
                buzz_cnt <= buzz_cnt - 1'b1;
            end
        end
    end

    assign score_t0 = score0;
    assign score_t1 = score1;
    assign tens_t0  = 4'(score0 / 7'd10);
    assign units_t0 = 4'(score0 % 7'd10);
    assign tens_t1  = 4'(score1 / 7'd10);
    assign units_t1 = 4'(score1 % 7'd10);

endmodule

// File: tb/tb_score_keeper.sv
// Self-checking bench for score_keeper: directed scenarios plus randomized
// operations checked against a score/legality model of the scoreboard.
module tb_score_keeper;

    localparam int DEB  = 4;
    localparam int BUZZ = 8;
    localparam int MAXS = 99;
    localparam int PE_AT     = 2 + DEB + 2;  // cycle of point_event after drive
    localparam int ALARM2_AT = 2 + DEB + 1;  // buzzer start for simultaneous edges
    localparam logic [63:0] PRESS = 64'h3FF;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       btn_a = 1'b0, btn_b = 1'b0, btn_c = 1'b0;
    logic       sub_mode = 1'b0, team_sel = 1'b0;
    logic [6:0] score_t0, score_t1;
    logic [3:0] tens_t0, units_t0, tens_t1, units_t1;
    logic [1:0] point_value;
    logic       point_event, buzzer, led;

    int checks = 0;
    int failures = 0;

    int m_score [2];
    int m_pv;
    int m_led;

    score_keeper #(.DEBOUNCE_CYCLES(DEB), .BUZZ_CYCLES(BUZZ), .MAX_SCORE(MAXS)) dut (
        .clk(clk), .reset_n(reset_n),
        .btn_a(btn_a), .btn_b(btn_b), .btn_c(btn_c),
        .sub_mode(sub_mode), .team_sel(team_sel),
        .score_t0(score_t0), .score_t1(score_t1),
        .tens_t0(tens_t0), .units_t0(units_t0),
        .tens_t1(tens_t1), .units_t1(units_t1),
        .point_value(point_value), .point_event(point_event),
        .buzzer(buzzer), .led(led)
    );

    always #5 clk = ~clk;

    // Apply one operation to the model using the scoreboard rules.
    task automatic model_apply(input int team, input int sub, input int v, output bit legal);
        int s;
        s = m_score[team];
        legal = sub ? (v <= s) : (s + v <= MAXS);
        if (legal) begin
            m_score[team] = sub ? s - v : s + v;
            m_pv  = v;
            m_led = 0;
        end else begin
            m_led = 1;
        end
    endtask

    // Drive bit i of each pattern during cycle i; count event/buzzer cycles.
    // Starts and ends just after a rising edge.
    task automatic run_seq(input logic [63:0] pa, input logic [63:0] pb, input logic [63:0] pc,
                           input int team, input int sub, input int total,
                           output int pe_cnt, output int bz_cnt,
                           output int pe_first, output int bz_first);
        pe_cnt = 0; bz_cnt = 0; pe_first = -1; bz_first = -1;
        team_sel = team[0];
        sub_mode = sub[0];
        for (int i = 0; i < total; i++) begin
            btn_a = pa[i];
            btn_b = pb[i];
            btn_c = pc[i];
            @(negedge clk);
            if (point_event === 1'b1) begin
                if (pe_first < 0) pe_first = i;
                pe_cnt++;
            end
            if (buzzer === 1'b1) begin
                if (bz_first < 0) bz_first = i;
                bz_cnt++;
            end
            @(posedge clk);
            #1;
        end
        btn_a = 1'b0; btn_b = 1'b0; btn_c = 1'b0;
    endtask

    task automatic press(input int v, input int team, input int sub,
                         output int pe_cnt, output int bz_cnt,
                         output int pe_first, output int bz_first);
        run_seq((v == 1) ? PRESS : 64'h0, (v == 2) ? PRESS : 64'h0, (v == 3) ? PRESS : 64'h0,
                team, sub, 24, pe_cnt, bz_cnt, pe_first, bz_first);
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++; if (score_t0 !== 7'd0) begin failures++; $display("FAIL reset_score_t0: got %0d expected 0", score_t0); end
        checks++; if (score_t1 !== 7'd0) begin failures++; $display("FAIL reset_score_t1: got %0d expected 0", score_t1); end
        checks++; if ({tens_t0, units_t0, tens_t1, units_t1} !== 16'h0) begin failures++; $display("FAIL reset_bcd: got %h expected 0000", {tens_t0, units_t0, tens_t1, units_t1}); end
        checks++; if (point_value !== 2'd0) begin failures++; $display("FAIL reset_point_value: got %0d expected 0", point_value); end
        checks++; if ({point_event, buzzer, led} !== 3'b000) begin failures++; $display("FAIL reset_flags: got %b expected 000", {point_event, buzzer, led}); end
        @(posedge clk); #1;
        reset_n = 1'b1;
        @(posedge clk); #1;
        m_score[0] = 0; m_score[1] = 0; m_pv = 0; m_led = 0;
    endtask

    task automatic test_single_press();
        int pe, bz, pf, bf; bit legal;
        press(3, 0, 0, pe, bz, pf, bf);
        model_apply(0, 0, 3, legal);
        checks++; if (pe !== 1) begin failures++; $display("FAIL single_event_cycles: got %0d expected 1", pe); end
        checks++; if (pf !== PE_AT) begin failures++; $display("FAIL single_latency: got %0d expected %0d", pf, PE_AT); end
        checks++; if (bz !== 0) begin failures++; $display("FAIL single_buzzer: got %0d expected 0", bz); end
        checks++; if (score_t0 !== 7'd3) begin failures++; $display("FAIL single_score_t0: got %0d expected 3", score_t0); end
        checks++; if ({tens_t0, units_t0} !== 8'h03) begin failures++; $display("FAIL single_bcd_t0: got %h expected 03", {tens_t0, units_t0}); end
        checks++; if (point_value !== 2'd3) begin failures++; $display("FAIL single_point_value: got %0d expected 3", point_value); end
        checks++; if (score_t1 !== 7'd0) begin failures++; $display("FAIL single_score_t1: got %0d expected 0", score_t1); end
        checks++; if (led !== 1'b0) begin failures++; $display("FAIL single_led: got %b expected 0", led); end
    endtask

    task automatic test_glitch();
        int pe, bz, pf, bf;
        run_seq(64'h5, 64'h0, 64'h0, 0, 0, 20, pe, bz, pf, bf);
        checks++; if (pe !== 0 || bz !== 0) begin failures++; $display("FAIL glitch_activity: got event=%0d buzz=%0d expected 0/0", pe, bz); end
        checks++; if (score_t0 !== 7'(m_score[0]) || score_t1 !== 7'(m_score[1])) begin failures++; $display("FAIL glitch_scores: got %0d/%0d expected %0d/%0d", score_t0, score_t1, m_score[0], m_score[1]); end
    endtask

    task automatic test_overflow();
        int pe, bz, pf, bf; bit legal;
        for (int k = 0; k < 32; k++) begin
            press(3, 1, 0, pe, bz, pf, bf);
            model_apply(1, 0, 3, legal);
        end
        press(2, 1, 0, pe, bz, pf, bf);
        model_apply(1, 0, 2, legal);
        checks++; if (score_t1 !== 7'd98) begin failures++; $display("FAIL ovf_setup_t1: got %0d expected 98", score_t1); end
        press(2, 1, 0, pe, bz, pf, bf);
        model_apply(1, 0, 2, legal);
        checks++; if (pe !== 0) begin failures++; $display("FAIL ovf_event: got %0d expected 0", pe); end
        checks++; if (bz !== BUZZ) begin failures++; $display("FAIL ovf_buzz_cycles: got %0d expected %0d", bz, BUZZ); end
        checks++; if (bf !== PE_AT) begin failures++; $display("FAIL ovf_buzz_start: got %0d expected %0d", bf, PE_AT); end
        checks++; if (score_t1 !== 7'd98) begin failures++; $display("FAIL ovf_score_t1: got %0d expected 98", score_t1); end
        checks++; if (led !== 1'b1) begin failures++; $display("FAIL ovf_led: got %b expected 1", led); end
        press(1, 1, 0, pe, bz, pf, bf);
        model_apply(1, 0, 1, legal);
        checks++; if (score_t1 !== 7'd99 || {tens_t1, units_t1} !== 8'h99) begin failures++; $display("FAIL ovf_max_t1: got %0d bcd %h expected 99 bcd 99", score_t1, {tens_t1, units_t1}); end
        checks++; if (led !== 1'b0 || pe !== 1) begin failures++; $display("FAIL ovf_led_clear: got led=%b event=%0d expected 0/1", led, pe); end
    endtask

    task automatic test_underflow();
        int pe, bz, pf, bf; bit legal;
        press(2, 0, 1, pe, bz, pf, bf);
        model_apply(0, 1, 2, legal);
        checks++; if (score_t0 !== 7'd1) begin failures++; $display("FAIL udf_setup_t0: got %0d expected 1", score_t0); end
        press(2, 0, 1, pe, bz, pf, bf);
        model_apply(0, 1, 2, legal);
        checks++; if (score_t0 !== 7'd1 || pe !== 0) begin failures++; $display("FAIL udf_reject: got score=%0d event=%0d expected 1/0", score_t0, pe); end
        checks++; if (bz !== BUZZ || led !== 1'b1) begin failures++; $display("FAIL udf_alarm: got buzz=%0d led=%b expected %0d/1", bz, led, BUZZ); end
        press(1, 0, 1, pe, bz, pf, bf);
        model_apply(0, 1, 1, legal);
        checks++; if (score_t0 !== 7'd0 || pe !== 1 || point_value !== 2'd1) begin failures++; $display("FAIL udf_to_zero: got score=%0d event=%0d pv=%0d expected 0/1/1", score_t0, pe, point_value); end
    endtask

    task automatic test_simultaneous();
        int pe, bz, pf, bf;
        run_seq(PRESS, PRESS, PRESS << 2, 0, 0, 30, pe, bz, pf, bf);
        m_led = 1;
        checks++; if (pe !== 0) begin failures++; $display("FAIL simul_event: got %0d expected 0", pe); end
        checks++; if (bz !== BUZZ || bf !== ALARM2_AT) begin failures++; $display("FAIL simul_buzz: got cycles=%0d start=%0d expected %0d/%0d", bz, bf, BUZZ, ALARM2_AT); end
        checks++; if (score_t0 !== 7'(m_score[0]) || score_t1 !== 7'(m_score[1])) begin failures++; $display("FAIL simul_scores: got %0d/%0d expected %0d/%0d", score_t0, score_t1, m_score[0], m_score[1]); end
        checks++; if (led !== 1'b1) begin failures++; $display("FAIL simul_led: got %b expected 1", led); end
    endtask

    task automatic test_random();
        int pe, bz, pf, bf, v, team, sub; bit legal;
        for (int n = 0; n < 24; n++) begin
            v    = int'($urandom_range(1, 3));
            team = int'($urandom_range(0, 1));
            sub  = ($urandom_range(0, 2) == 0) ? 1 : 0;
            press(v, team, sub, pe, bz, pf, bf);
            model_apply(team, sub, v, legal);
            checks++;
            if (legal ? (pe !== 1 || bz !== 0) : (pe !== 0 || bz !== BUZZ)) begin
                failures++; $display("FAIL rand_outcome op%0d: got event=%0d buzz=%0d expected legal=%0d", n, pe, bz, legal);
            end
            checks++;
            if (score_t0 !== 7'(m_score[0]) || score_t1 !== 7'(m_score[1])) begin
                failures++; $display("FAIL rand_scores op%0d: got %0d/%0d expected %0d/%0d", n, score_t0, score_t1, m_score[0], m_score[1]);
            end
            checks++;
            if ({tens_t0, units_t0, tens_t1, units_t1} !== {4'(m_score[0] / 10), 4'(m_score[0] % 10), 4'(m_score[1] / 10), 4'(m_score[1] % 10)}) begin
                failures++; $display("FAIL rand_bcd op%0d: got %h expected scores %0d/%0d", n, {tens_t0, units_t0, tens_t1, units_t1}, m_score[0], m_score[1]);
            end
            checks++;
            if (point_value !== 2'(m_pv) || led !== m_led[0]) begin
                failures++; $display("FAIL rand_pv_led op%0d: got pv=%0d led=%b expected %0d/%0d", n, point_value, led, m_pv, m_led);
            end
        end
    endtask

    task automatic test_reset_mid();
        int pe, bz, pf, bf; bit legal;
        press(1, 0, 0, pe, bz, pf, bf);
        model_apply(0, 0, 1, legal);
        team_sel = 1'b0; sub_mode = 1'b0;
        btn_a = 1'b1;
        repeat (PE_AT - 1) begin
            @(posedge clk); #1;
        end
        reset_n = 1'b0;
        btn_a = 1'b0;
        @(negedge clk);
        checks++; if (score_t0 !== 7'd0 || score_t1 !== 7'd0) begin failures++; $display("FAIL midrst_scores: got %0d/%0d expected 0/0", score_t0, score_t1); end
        checks++; if ({point_value, point_event, buzzer, led} !== 5'b0) begin failures++; $display("FAIL midrst_outputs: got %b expected 00000", {point_value, point_event, buzzer, led}); end
        @(posedge clk); #1;
        reset_n = 1'b1;
        m_score[0] = 0; m_score[1] = 0; m_pv = 0; m_led = 0;
        run_seq(64'h0, 64'h0, 64'h0, 0, 0, 20, pe, bz, pf, bf);
        checks++; if (pe !== 0 || bz !== 0) begin failures++; $display("FAIL midrst_no_update: got event=%0d buzz=%0d expected 0/0", pe, bz); end
        checks++; if (score_t0 !== 7'd0 || point_value !== 2'd0) begin failures++; $display("FAIL midrst_after: got score=%0d pv=%0d expected 0/0", score_t0, point_value); end
    endtask

    initial begin
        test_reset();
        test_single_press();
        test_glitch();
        test_overflow();
        test_underflow();
        test_simultaneous();
        test_random();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
